lsu_sram: RTL

- Parametrised data memory for the RISC-V core's load/store path, replacing the word-only combinational-read bank.
- Adds a valid/ready request handshake, a registered 1-cycle read, and byte/halfword/word access selected by funct3, with sign/zero extension.
- Flags misaligned, out-of-range and illegal-size accesses with an error response.
- Zero-fills the array with a post-reset sweep FSM instead of a parallel reset of every word.

---
 rtl/lsu_pkg.sv | 15 +
 rtl/sram_bank.sv | 27 ++
 rtl/lsu_sram.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store SRAM: funct3 access encodings and controller states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    CLEAR,
    READY
  } lsu_state_t;

endpackage

// File: rtl/sram_bank.sv
// Word-organised storage array with per-byte write enables and a registered read port.
module sram_bank #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];

  // Storage has no reset; zero-filling is the controller's job.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) r_mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= r_mem[raddr];
  end

endmodule

// File: rtl/lsu_sram.sv
// Load/store data memory: request handshake, zero-fill sweep after reset,
// byte/halfword/word access with sign/zero extension and error responses.
module lsu_sram
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IW = $clog2(DEPTH);

  lsu_state_t      r_state, w_nextState;
  logic [IW-1:0]   r_idx;
  logic            r_pend, r_rspErr, r_ldOk;
  logic [2:0]      r_size;
  logic [1:0]      r_lane;
  logic [XLEN-1:0] r_rdataHold;

  logic            w_accept, w_oor, w_mis, w_ill, w_err;
  logic [IW-1:0]   w_wordIdx;
  logic [1:0]      w_lane;
  logic [ADDR_W-1:0] w_hiAddr;
  logic            w_bankWe;
  logic [3:0]      w_bankBe;
  logic [IW-1:0]   w_bankWaddr;
  logic [XLEN-1:0] w_bankWdata, w_bankRdata, w_shifted, w_ldData;

  assign w_wordIdx = req_addr[IW+1:2];
  assign w_lane    = req_addr[1:0];
  assign w_hiAddr  = req_addr >> (IW + 2);

  assign req_ready = (r_state == READY) && !rst;
  assign busy      = (r_state == CLEAR);
  assign w_accept  = req_valid && req_ready;

  assign w_oor = |w_hiAddr;
  assign w_mis = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_size[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_ill = req_we ? !(req_size inside {F3_B, F3_H, F3_W})
                        : (req_size inside {3'b011, 3'b110, 3'b111});
  assign w_err = w_oor || w_mis || w_ill;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      CLEAR: if (r_idx == IW'(DEPTH - 1)) w_nextState = READY;
      READY: w_nextState = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CLEAR_ON_RESET ? CLEAR : READY;
      r_idx       <= '0;
      r_pend      <= 1'b0;
      r_rspErr    <= 1'b0;
      r_ldOk      <= 1'b0;
      r_size      <= '0;
      r_lane      <= '0;
      r_rdataHold <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == CLEAR) r_idx <= r_idx + 1'b1;
      r_pend <= w_accept;
      if (w_accept) begin
        r_rspErr <= w_err;
        r_ldOk   <= !req_we && !w_err;
        r_size   <= req_size;
        r_lane   <= w_lane;
      end
      if (r_pend) r_rdataHold <= w_ldData;
    end
  end

  // Stores replicate the data across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    w_bankWe    = 1'b0;
    w_bankBe    = 4'b0000;
    w_bankWaddr = w_wordIdx;
    w_bankWdata = req_wdata;
    if (r_state == CLEAR && !rst) begin
      w_bankWe    = 1'b1;
      w_bankBe    = 4'b1111;
      w_bankWaddr = r_idx;
      w_bankWdata = '0;
    end else if (w_accept && req_we && !w_err) begin
      w_bankWe = 1'b1;
      case (req_size[1:0])
        2'b00: begin
          w_bankBe    = 4'b0001 << w_lane;
          w_bankWdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          w_bankBe    = w_lane[1] ? 4'b1100 : 4'b0011;
          w_bankWdata = {2{req_wdata[15:0]}};
        end
        default: begin
          w_bankBe    = 4'b1111;
          w_bankWdata = req_wdata;
        end
      endcase
    end
  end

  sram_bank #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk   (clk),
    .we    (w_bankWe),
    .be    (w_bankBe),
    .waddr (w_bankWaddr),
    .wdata (w_bankWdata),
    .raddr (w_wordIdx),
    .rdata (w_bankRdata)
  );

  assign w_shifted = w_bankRdata >> {r_lane, 3'b000};

  always_comb begin
    w_ldData = '0;
    if (r_ldOk) begin
      case (r_size)
        F3_B:    w_ldData = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
        F3_H:    w_ldData = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
        F3_W:    w_ldData = w_bankRdata;
        F3_BU:   w_ldData = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
        F3_HU:   w_ldData = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
        default: w_ldData = '0;
      endcase
    end
  end

  // A reset in the response cycle kills the pulse; data holds between responses.
  assign rsp_valid = r_pend && !rst;
  assign rsp_rdata = rsp_valid ? w_ldData : r_rdataHold;
  assign rsp_err   = r_rspErr;

endmodule
